// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for MULTU/DIVU: iterative radix-2 shift-add multiply and restoring divide,
// one iteration per bit, with a pipeline stall while a result is pending.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hi_used,
  input  logic             lo_used,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_div;
  logic               r_dz;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_oper;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_borrow;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Both algorithms share one accumulator laid out as {hi, lo}: multiply keeps
  // {partial product, remaining multiplier}, divide keeps {remainder, quotient/dividend}.
  always_comb begin
    w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_oper} : '0);
    w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_borrow  = (w_shift < {1'b0, r_oper});
    w_rem_sub = w_shift[WIDTH-1:0] - r_oper;
    if (r_div) begin
      if (w_borrow) w_acc_nxt = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      else          w_acc_nxt = {w_rem_sub, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_nxt = {w_msum, r_acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_accept    = start & (r_state != S_RUN);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
      r_oper  <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_div  <= op_div;
        r_dz   <= op_div & (opb == '0);
        r_oper <= op_div ? opb : opa;
        r_acc  <= {{WIDTH{1'b0}}, (op_div ? opa : opb)};
        r_cnt  <= '0;
      end else if (r_state == S_RUN) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == LAST) {r_hi, r_lo} <= w_acc_nxt;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign div_zero = done & r_dz;
  assign stall    = busy & (start | hi_used | lo_used);
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
